// File: rtl/vga_fb_pkg.sv
// Shared types and constants for the VGA framebuffer arbiter: bus states,
// write FIFO entry layout and the pixel address function.
package vga_fb_pkg;

    localparam int H_ACT  = 640;
    localparam int V_ACT  = 480;
    localparam int ADDR_W = 19;
    localparam int DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } bus_state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_entry_t;

    // y*640 + x as shifts and adds (640 = 512 + 128).
    function automatic logic [ADDR_W-1:0] pix_addr(input logic [9:0] x, input logic [9:0] y);
        logic [ADDR_W-1:0] xw;
        logic [ADDR_W-1:0] yw;
        xw = ADDR_W'(x);
        yw = ADDR_W'(y);
        return (yw << 9) + (yw << 7) + xw;
    endfunction

endpackage

// File: rtl/fb_wr_fifo.sv
// Synchronous FIFO of pending frame writes with a registered "not full" ready.
module fb_wr_fifo
    import vga_fb_pkg::*;
#(
    parameter int FIFO_DEPTH = 8
) (
    input  logic      clk_i,
    input  logic      rst_n_i,
    input  logic      push_i,
    input  logic      pop_i,
    input  wr_entry_t din_i,
    output wr_entry_t dout_o,
    output logic      empty_o,
    output logic      ready_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_CNT = (AW+1)'(FIFO_DEPTH);

    wr_entry_t     mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic [AW:0]   count_d;
    logic          ready_q;
    logic          do_push;
    logic          do_pop;

    assign empty_o = (count_q == '0);
    assign ready_o = ready_q;
    assign dout_o  = mem_q[rd_ptr_q];

    // ready_q is exactly "not full", so gating push on it also guards overflow.
    assign do_push = push_i && ready_q;
    assign do_pop  = pop_i && !empty_o;
    assign count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ready_q  <= 1'b0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
            ready_q <= (count_d != DEPTH_CNT);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= din_i;
    end

endmodule

// File: rtl/vga_fb_arbiter.sv
// Single-port pixel SRAM arbiter: VGA fetches always win, buffered frame
// writes drain into cycles the VGA leaves free.
module vga_fb_arbiter #(
    parameter int DATA_W     = 16,
    parameter int H_ACT      = 640,
    parameter int V_ACT      = 480,
    parameter int ADDR_W     = 19,
    parameter int FIFO_DEPTH = 8
) (
    input  logic              iCLK,
    input  logic              iRST_N,
    input  logic              iRd_req,
    input  logic [9:0]        iRd_x,
    input  logic [9:0]        iRd_y,
    output logic [DATA_W-1:0] oRd_data,
    output logic              oRd_valid,
    input  logic              iWr_valid,
    output logic              oWr_ready,
    input  logic [9:0]        iWr_x,
    input  logic [9:0]        iWr_y,
    input  logic [DATA_W-1:0] iWr_data,
    output logic [ADDR_W-1:0] oMem_addr,
    output logic [DATA_W-1:0] oMem_wdata,
    output logic              oMem_we_n,
    output logic              oMem_oe_n,
    input  logic [DATA_W-1:0] iMem_rdata,
    output logic [15:0]       oStall_cnt
);
    import vga_fb_pkg::*;

    localparam logic [9:0] H_LIM = 10'(H_ACT);
    localparam logic [9:0] V_LIM = 10'(V_ACT);

    bus_state_t        bus_q, bus_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              we_n_q, we_n_d;
    logic              oe_n_q, oe_n_d;
    logic [DATA_W-1:0] rd_data_q;
    logic              rd_valid_q;
    logic [15:0]       stall_q;

    wr_entry_t         fifo_din;
    wr_entry_t         fifo_head;
    logic              fifo_empty;
    logic              fifo_ready;
    logic              wr_push;
    logic              wr_pop;

    // Out-of-range pixels complete the handshake but are dropped here.
    assign wr_push       = iWr_valid && fifo_ready && (iWr_x < H_LIM) && (iWr_y < V_LIM);
    assign wr_pop        = !iRd_req && !fifo_empty;
    assign fifo_din.addr = pix_addr(iWr_x, iWr_y);
    assign fifo_din.data = iWr_data;

    fb_wr_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i   (iCLK),
        .rst_n_i (iRST_N),
        .push_i  (wr_push),
        .pop_i   (wr_pop),
        .din_i   (fifo_din),
        .dout_o  (fifo_head),
        .empty_o (fifo_empty),
        .ready_o (fifo_ready)
    );

    always_comb begin
        bus_d   = IDLE;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_n_d  = 1'b1;
        oe_n_d  = 1'b1;
        if (iRd_req) begin
            bus_d  = READ;
            addr_d = pix_addr(iRd_x, iRd_y);
            oe_n_d = 1'b0;
        end else if (!fifo_empty) begin
            bus_d   = WRITE;
            addr_d  = fifo_head.addr;
            wdata_d = fifo_head.data;
            we_n_d  = 1'b0;
        end
    end

    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            bus_q      <= IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            we_n_q     <= 1'b1;
            oe_n_q     <= 1'b1;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            stall_q    <= '0;
        end else begin
            bus_q   <= bus_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_n_q  <= we_n_d;
            oe_n_q  <= oe_n_d;
            // The SRAM answers the address registered last edge; capture it now.
            rd_valid_q <= (bus_q == READ);
            if (bus_q == READ) rd_data_q <= iMem_rdata;
            if (iRd_req && !fifo_empty && (stall_q != 16'hFFFF)) stall_q <= stall_q + 16'd1;
        end
    end

    assign oRd_data   = rd_data_q;
    assign oRd_valid  = rd_valid_q;
    assign oWr_ready  = fifo_ready;
    assign oMem_addr  = addr_q;
    assign oMem_wdata = wdata_q;
    assign oMem_we_n  = we_n_q;
    assign oMem_oe_n  = oe_n_q;
    assign oStall_cnt = stall_q;

endmodule
